// File: rtl/pc_sequencer_pkg.sv
// Shared constants, action encoding and helpers for the PIC-style program counter sequencer.
// Optional feature macro: PC_SEQUENCER_STACK_FLAGS_EN (sticky stack overflow/underflow flags).
package pc_sequencer_pkg;

  localparam int unsigned DEF_PC_W        = 13;
  localparam int unsigned DEF_JADDR_W     = 11;
  localparam int unsigned DEF_PCLATH_W    = 5;
  localparam int unsigned DEF_STACK_DEPTH = 8;
  localparam int unsigned DEF_INT_VECTOR  = 4;
  localparam int unsigned RESET_VECTOR    = 0;

  // One PC action per cycle, listed in decreasing priority.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INT,
    OP_CALL,
    OP_GOTO,
    OP_RET,
    OP_PCL,
    OP_SKIP,
    OP_INCR
  } pc_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular hardware return stack with level tracking; wraps like the PIC16F stack.
// Sticky ovf/unf flags exist only when PC_SEQUENCER_STACK_FLAGS_EN is defined.
module pc_return_stack
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [PC_W-1:0]               din,
  output logic [PC_W-1:0]               tos,
  output logic [clog2(STACK_DEPTH):0]   level,
  output logic                          ovf,
  output logic                          unf,
  input  logic                          err_clr
);

  localparam int unsigned SP_W  = clog2(STACK_DEPTH);
  localparam int unsigned LVL_W = SP_W + 1;

  logic [PC_W-1:0]  mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [LVL_W-1:0] lvl;
  logic             full;
  logic             empty;

  assign full  = (lvl == LVL_W'(STACK_DEPTH));
  assign empty = (lvl == '0);
  assign tos   = mem[sp - SP_W'(1)];
  assign level = lvl;

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= din;
  end

  // sp always moves (circular); only the level saturates at 0 and DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp  <= '0;
      lvl <= '0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
      if (!full) lvl <= lvl + LVL_W'(1);
    end else if (pop) begin
      sp <= sp - SP_W'(1);
      if (!empty) lvl <= lvl - LVL_W'(1);
    end
  end

`ifdef PC_SEQUENCER_STACK_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push && full)               ovf <= 1'b1;
      else if (err_clr)               ovf <= 1'b0;
      if (pop && !push && empty)      unf <= 1'b1;
      else if (err_clr)               unf <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter, PCLATH register and priority action mux in front of the return stack.
// Optional feature macro: PC_SEQUENCER_STACK_FLAGS_EN (enables stack_ovf/stack_unf/stack_err_clr).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned JADDR_W     = DEF_JADDR_W,
  parameter int unsigned PCLATH_W    = DEF_PCLATH_W,
  parameter int unsigned STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int unsigned INT_VECTOR  = DEF_INT_VECTOR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pc_incr_en,
  input  logic                          pc_skip_en,
  input  logic                          pc_j_en,
  input  logic                          pc_j_and_push_en,
  input  logic                          pc_j_by_pop_en,
  input  logic                          pc_int_en,
  input  logic [JADDR_W-1:0]            pc_j_addr,
  input  logic                          pclath_wr_en,
  input  logic [PCLATH_W-1:0]           pclath_in,
  input  logic                          pcl_wr_en,
  input  logic [7:0]                    pcl_in,
  output logic [PC_W-1:0]               pc_out,
  output logic [PCLATH_W-1:0]           pclath_out,
  output logic [clog2(STACK_DEPTH):0]   stack_level,
  output logic                          stack_ovf,
  output logic                          stack_unf,
  input  logic                          stack_err_clr
);

  localparam int unsigned HI_W = PC_W - JADDR_W;

  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     pc_d;
  logic [PC_W-1:0]     tos;
  logic [PC_W-1:0]     goto_addr;
  logic [PC_W-1:0]     pcl_addr;
  logic [PCLATH_W-1:0] pclath_q;
  logic                push;
  logic                pop;
  pc_op_e              op;

  // Jump targets use the registered PCLATH, so a same-cycle PCLATH write takes effect later.
  assign goto_addr = {pclath_q[PCLATH_W-1 -: HI_W], pc_j_addr};
  assign pcl_addr  = {pclath_q[PC_W-9:0], pcl_in};

  always_comb begin
    op = OP_HOLD;
    if      (pc_int_en)        op = OP_INT;
    else if (pc_j_and_push_en) op = OP_CALL;
    else if (pc_j_en)          op = OP_GOTO;
    else if (pc_j_by_pop_en)   op = OP_RET;
    else if (pcl_wr_en)        op = OP_PCL;
    else if (pc_skip_en)       op = OP_SKIP;
    else if (pc_incr_en)       op = OP_INCR;
  end

  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    case (op)
      OP_INT:  begin pc_d = PC_W'(INT_VECTOR); push = 1'b1; end
      OP_CALL: begin pc_d = goto_addr;         push = 1'b1; end
      OP_GOTO: pc_d = goto_addr;
      OP_RET:  begin pc_d = tos;               pop  = 1'b1; end
      OP_PCL:  pc_d = pcl_addr;
      OP_SKIP: pc_d = pc_q + PC_W'(2);
      OP_INCR: pc_d = pc_q + PC_W'(1);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_W'(RESET_VECTOR);
      pclath_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (pclath_wr_en) pclath_q <= pclath_in;
    end
  end

  assign pc_out     = pc_q;
  assign pclath_out = pclath_q;

  pc_return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (pc_q),
    .tos     (tos),
    .level   (stack_level),
    .ovf     (stack_ovf),
    .unf     (stack_unf),
    .err_clr (stack_err_clr)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus random bench for pc_sequencer against a behavioural PC/stack model.
// Flag expectations follow PC_SEQUENCER_STACK_FLAGS_EN.
module tb_pc_sequencer;

  localparam int unsigned PC_W     = 13;
  localparam int unsigned JADDR_W  = 11;
  localparam int unsigned PCLATH_W = 5;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned INT_VEC  = 4;
  localparam int unsigned PC_MOD   = 1 << PC_W;

`ifdef PC_SEQUENCER_STACK_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  localparam int unsigned C_INCR = 1;
  localparam int unsigned C_SKIP = 2;
  localparam int unsigned C_J    = 4;
  localparam int unsigned C_JP   = 8;
  localparam int unsigned C_POP  = 16;
  localparam int unsigned C_INT  = 32;
  localparam int unsigned C_LW   = 64;
  localparam int unsigned C_PCL  = 128;
  localparam int unsigned C_CLR  = 256;

  logic                clk = 1'b0;
  logic                rst;
  logic                pc_incr_en, pc_skip_en, pc_j_en, pc_j_and_push_en;
  logic                pc_j_by_pop_en, pc_int_en, pclath_wr_en, pcl_wr_en, stack_err_clr;
  logic [JADDR_W-1:0]  pc_j_addr;
  logic [PCLATH_W-1:0] pclath_in;
  logic [7:0]          pcl_in;
  logic [PC_W-1:0]     pc_out;
  logic [PCLATH_W-1:0] pclath_out;
  logic [3:0]          stack_level;
  logic                stack_ovf, stack_unf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_pc, m_pclath, m_sp, m_lvl;
  bit          m_ovf, m_unf;
  int unsigned m_mem [DEPTH];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .pc_incr_en       (pc_incr_en),
    .pc_skip_en       (pc_skip_en),
    .pc_j_en          (pc_j_en),
    .pc_j_and_push_en (pc_j_and_push_en),
    .pc_j_by_pop_en   (pc_j_by_pop_en),
    .pc_int_en        (pc_int_en),
    .pc_j_addr        (pc_j_addr),
    .pclath_wr_en     (pclath_wr_en),
    .pclath_in        (pclath_in),
    .pcl_wr_en        (pcl_wr_en),
    .pcl_in           (pcl_in),
    .pc_out           (pc_out),
    .pclath_out       (pclath_out),
    .stack_level      (stack_level),
    .stack_ovf        (stack_ovf),
    .stack_unf        (stack_unf),
    .stack_err_clr    (stack_err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},     32'(pc_out),      m_pc);
    check({tag, ".pclath"}, 32'(pclath_out),  m_pclath);
    check({tag, ".level"},  32'(stack_level), m_lvl);
    check({tag, ".ovf"},    32'(stack_ovf),   32'(m_ovf));
    check({tag, ".unf"},    32'(stack_unf),   32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc = 0; m_pclath = 0; m_sp = 0; m_lvl = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic drive_idle();
    {pc_incr_en, pc_skip_en, pc_j_en, pc_j_and_push_en, pc_j_by_pop_en} = '0;
    {pc_int_en, pclath_wr_en, pcl_wr_en, stack_err_clr} = '0;
    pc_j_addr = '0; pclath_in = '0; pcl_in = '0;
  endtask

  // One clock of stimulus; the model advances using the pre-edge state only.
  task automatic cycle(input int unsigned ctl, input int unsigned ja,
                       input int unsigned pl, input int unsigned pcl, input string tag);
    int unsigned goto_t, nxt;
    bit push, pop, full, empty;
    pc_incr_en       = (ctl & C_INCR) != 0;
    pc_skip_en       = (ctl & C_SKIP) != 0;
    pc_j_en          = (ctl & C_J)    != 0;
    pc_j_and_push_en = (ctl & C_JP)   != 0;
    pc_j_by_pop_en   = (ctl & C_POP)  != 0;
    pc_int_en        = (ctl & C_INT)  != 0;
    pclath_wr_en     = (ctl & C_LW)   != 0;
    pcl_wr_en        = (ctl & C_PCL)  != 0;
    stack_err_clr    = (ctl & C_CLR)  != 0;
    pc_j_addr        = JADDR_W'(ja);
    pclath_in        = PCLATH_W'(pl);
    pcl_in           = 8'(pcl);

    goto_t = ((m_pclath >> (PCLATH_W - (PC_W - JADDR_W))) << JADDR_W) | (ja % (1 << JADDR_W));
    nxt = m_pc; push = 0; pop = 0;
    if (pc_int_en)             begin nxt = INT_VEC; push = 1; end
    else if (pc_j_and_push_en) begin nxt = goto_t;  push = 1; end
    else if (pc_j_en)          nxt = goto_t;
    else if (pc_j_by_pop_en)   begin nxt = m_mem[(m_sp + DEPTH - 1) % DEPTH]; pop = 1; end
    else if (pcl_wr_en)        nxt = ((m_pclath % (1 << (PC_W - 8))) << 8) | (pcl % 256);
    else if (pc_skip_en)       nxt = (m_pc + 2) % PC_MOD;
    else if (pc_incr_en)       nxt = (m_pc + 1) % PC_MOD;

    full  = (m_lvl == DEPTH);
    empty = (m_lvl == 0);
    if (FLAGS && stack_err_clr) begin m_ovf = 0; m_unf = 0; end
    if (push) begin
      m_mem[m_sp] = m_pc;
      m_sp = (m_sp + 1) % DEPTH;
      if (full) m_ovf = FLAGS; else m_lvl++;
    end else if (pop) begin
      m_sp = (m_sp + DEPTH - 1) % DEPTH;
      if (empty) m_unf = FLAGS; else m_lvl--;
    end
    m_pc = nxt;
    if (pclath_wr_en) m_pclath = pl % (1 << PCLATH_W);

    @(posedge clk);
    #1;
    drive_idle();
    check_model(tag);
  endtask

  initial begin
    int unsigned ctl;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    drive_idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_model("reset");

    // Increment and asynchronous reset mid-cycle
    cycle(C_INCR, 0, 0, 0, "incr1"); check("incr1.abs", 32'(pc_out), 1);
    cycle(C_INCR, 0, 0, 0, "incr2"); check("incr2.abs", 32'(pc_out), 2);
    cycle(C_INCR, 0, 0, 0, "incr3"); check("incr3.abs", 32'(pc_out), 3);
    #3 rst = 1'b1;
    #1 check("async_rst.pc", 32'(pc_out), 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    check_model("after_rst");

    // GOTO with concurrent PCLATH write uses the old PCLATH
    cycle(C_LW, 0, 'h18, 0, "lath18");
    cycle(C_J | C_LW, 'h123, 'h00, 0, "goto");
    check("goto.abs", 32'(pc_out), 'h1923);
    check("goto.lath", 32'(pclath_out), 'h00);

    // CALL / RETURN
    cycle(C_J, 'h050, 0, 0, "set50");
    cycle(C_JP, 'h200, 0, 0, "call");
    check("call.abs", 32'(pc_out), 'h0200);
    check("call.lvl", 32'(stack_level), 1);
    cycle(C_POP, 0, 0, 0, "ret");
    check("ret.abs", 32'(pc_out), 'h0050);
    check("ret.lvl", 32'(stack_level), 0);

    // Interrupt beats CALL, single push
    cycle(C_J, 'h077, 0, 0, "set77");
    cycle(C_INT | C_JP, 'h300, 0, 0, "int");
    check("int.abs", 32'(pc_out), 'h0004);
    check("int.lvl", 32'(stack_level), 1);
    cycle(C_SKIP, 0, 0, 0, "skip");
    check("skip.abs", 32'(pc_out), 'h0006);
    cycle(C_POP | C_JP, 'h100, 0, 0, "call_ret");
    check("call_ret.lvl", 32'(stack_level), 2);
    cycle(C_POP, 0, 0, 0, "ret_a");
    check("ret_a.abs", 32'(pc_out), 'h0006);
    cycle(C_POP, 0, 0, 0, "ret_b");
    check("ret_b.abs", 32'(pc_out), 'h0077);

    // Overflow / underflow
    cycle(C_CLR | C_J, 'h010, 0, 0, "set10");
    for (int i = 0; i < 9; i++) cycle(C_JP, 'h11 + i, 0, 0, "calln");
    check("ovf.lvl", 32'(stack_level), 8);
    check("ovf.flag", 32'(stack_ovf), 32'(FLAGS));
    for (int i = 0; i < 8; i++) begin
      cycle(C_POP, 0, 0, 0, "retn");
      check("retn.abs", 32'(pc_out), 'h18 - i);
    end
    cycle(C_POP, 0, 0, 0, "unf");
    check("unf.flag", 32'(stack_unf), 32'(FLAGS));
    check("unf.lvl", 32'(stack_level), 0);
    check("unf.stale", 32'(pc_out), 'h18);
    cycle(C_POP | C_CLR, 0, 0, 0, "unf_clr_race");
    check("race.unf", 32'(stack_unf), 32'(FLAGS));
    cycle(C_CLR, 0, 0, 0, "clr");
    check("clr.ovf", 32'(stack_ovf), 0);
    check("clr.unf", 32'(stack_unf), 0);

    // Wrap and computed jump
    cycle(C_LW, 0, 'h18, 0, "lath18b");
    cycle(C_J, 'h7FF, 0, 0, "set1fff");
    cycle(C_SKIP, 0, 0, 0, "skipwrap");
    check("skipwrap.abs", 32'(pc_out), 'h0001);
    cycle(C_J, 'h7FF, 0, 0, "set1fffb");
    cycle(C_INCR, 0, 0, 0, "incrwrap");
    check("incrwrap.abs", 32'(pc_out), 'h0000);
    cycle(C_LW, 0, 'h1F, 0, "lath1f");
    cycle(C_PCL, 0, 0, 'hAB, "pcl");
    check("pcl.abs", 32'(pc_out), 'h1FAB);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ctl = $urandom_range(0, 511) & $urandom_range(0, 511) & $urandom_range(0, 511);
      cycle(ctl, $urandom, $urandom, $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
